// File: rtl/flash_buf_ctrl.sv
// Staging-buffer sequencer for the 4H board video RAM: CPU pointer port (A) and
// a valid/ready byte stream (B) to the SPI flash programmer. Optional CRC-8 under FLASH_BUF_CRC_EN.
//
// state | meaning
// IDLE  | waiting for start, stream outputs quiet
// FETCH | issuing port-B read addresses while the skid buffer has room
// DRAIN | all addresses issued, waiting for the final handshake
module flash_buf_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_addr_set,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_wr,
    input  logic [7:0]            cpu_din,
    input  logic                  cpu_rd,
    output logic [7:0]            cpu_dout,
    output logic                  cpu_dout_valid,
    output logic                  write_err,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  stream_len,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [7:0]            ram_din_a,
    input  logic [7:0]            ram_dout_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [7:0]            ram_dout_b,
    output logic [7:0]            crc
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_MAX = {1'b1, {(LEN_WIDTH-1){1'b0}}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] cpu_eff;
    logic                  cpu_wr_ok;
    logic                  cpu_rd_ok;
    logic                  rd_pend;

    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [LEN_WIDTH-1:0]  fetch_left;
    logic [LEN_WIDTH-1:0]  xfer_left;
    logic [LEN_WIDTH-1:0]  len_eff;
    logic                  rd_vld;
    logic                  skid_valid;
    logic [7:0]            skid_data;
    logic [1:0]            level;
    logic                  issue;
    logic                  accept;
    logic                  pop;
    logic                  last_pop;

    // ---------------- CPU port A ----------------
    assign cpu_eff    = cpu_addr_set ? cpu_addr : ptr;
    assign cpu_wr_ok  = cpu_wr && !busy && !rst;
    assign cpu_rd_ok  = cpu_rd && !cpu_wr;
    assign ram_addr_a = cpu_eff;
    assign ram_din_a  = cpu_din;
    assign ram_we_a   = cpu_wr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr            <= '0;
            rd_pend        <= 1'b0;
            cpu_dout       <= 8'h00;
            cpu_dout_valid <= 1'b0;
            write_err      <= 1'b0;
        end else begin
            rd_pend        <= cpu_rd_ok;
            cpu_dout_valid <= rd_pend;
            if (rd_pend)
                cpu_dout <= ram_dout_a;
            if (cpu_wr_ok || cpu_rd_ok)
                ptr <= cpu_eff + 1'b1;
            else if (cpu_addr_set)
                ptr <= cpu_addr;
            // a write dropped in the same cycle as addr_set still flags
            if (cpu_wr && busy)
                write_err <= 1'b1;
            else if (cpu_addr_set)
                write_err <= 1'b0;
        end
    end

    // ---------------- stream port B ----------------
    assign busy       = (state != IDLE);
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = fetch_addr;
    assign len_eff    = (stream_len == '0) ? LEN_MAX : stream_len;
    assign pop        = m_valid && m_ready;
    assign last_pop   = pop && (xfer_left == LEN_ONE);
    // buffered bytes plus the one in flight from the RAM
    assign level      = {1'b0, m_valid} + {1'b0, skid_valid} + {1'b0, rd_vld};

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                // issue only if the returning byte is guaranteed a slot next cycle
                issue = ((level - {1'b0, pop}) < 2'd2);
                if (issue && (fetch_left == LEN_ONE))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (last_pop)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_addr <= '0;
            fetch_left <= '0;
            xfer_left  <= '0;
            rd_vld     <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= 8'h00;
            skid_valid <= 1'b0;
            skid_data  <= 8'h00;
            done       <= 1'b0;
        end else begin
            done   <= last_pop;
            rd_vld <= issue;
            if (accept) begin
                fetch_addr <= start_addr;
                fetch_left <= len_eff;
                xfer_left  <= len_eff;
            end else begin
                if (issue) begin
                    fetch_addr <= fetch_addr + 1'b1;
                    fetch_left <= fetch_left - 1'b1;
                end
                if (pop)
                    xfer_left <= xfer_left - 1'b1;
            end

            if (pop || !m_valid) begin
                if (skid_valid) begin
                    m_data  <= skid_data;
                    m_valid <= 1'b1;
                    if (rd_vld)
                        skid_data <= ram_dout_b;
                    else
                        skid_valid <= 1'b0;
                end else if (rd_vld) begin
                    m_data  <= ram_dout_b;
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (rd_vld) begin
                skid_data  <= ram_dout_b;
                skid_valid <= 1'b1;
            end
        end
    end

`ifdef FLASH_BUF_CRC_EN
    logic [7:0] crc_q;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            crc_q <= 8'h00;
        else if (accept)
            crc_q <= 8'h00;
        else if (pop)
            crc_q <= crc8_byte(crc_q, m_data);
    end

    assign crc = crc_q;
`else
    assign crc = 8'h00;
`endif

endmodule
